qtest_dpram_avmm: RTL and testbench

//  Parametrised single-clock true-dual-port on-chip RAM with two Avalon-MM slaves:

---
 rtl/qtest_dpram_avmm.sv | 145 ++++++++++++++
 tb/tb_qtest_dpram_avmm.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/qtest_dpram_avmm.sv
// qtest_dpram_avmm
//   Single-clock true-dual-port RAM with two Avalon-MM slaves.
//   Port A (address/chipselect/read/write/writedata -> waitrequest/readdata/readdatavalid)
//     is DATA_W_A wide and addresses one byte lane at a time.
//   Port B (address2/.../byteenable2/writedata2 -> waitrequest2/readdata2/readdatavalid2)
//     is DATA_W_A*RATIO wide, word addressed, and byte enabled.
//   clk, reset (async, active-high), clken and reset_req act as a shared stall for both ports.
//   collision_cnt is a saturating count of same-cycle writes that hit the same lane.
//   Reads return data that has already been merged with any write accepted in the same cycle.
//   Read latency is 1 cycle, or 2 cycles when OUTREG=1. Stalled cycles do not count
//   toward the latency.
//   RAM contents are not initialised and are not cleared by reset.
module qtest_dpram_avmm #(
    parameter int unsigned DATA_W_A = 8,
    parameter int unsigned RATIO    = 8,
    parameter int unsigned DEPTH_B  = 16384,
    parameter int unsigned ADDR_W_B = 14,
    parameter bit          OUTREG   = 1'b0,
    localparam int unsigned DATA_W_B = DATA_W_A * RATIO,
    localparam int unsigned ADDR_W_A = ADDR_W_B + $clog2(RATIO)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clken,
    input  logic                reset_req,
    // port A (narrow)
    input  logic [ADDR_W_A-1:0] address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W_A-1:0] writedata,
    output logic                waitrequest,
    output logic [DATA_W_A-1:0] readdata,
    output logic                readdatavalid,
    // port B (wide, byte enabled)
    input  logic [ADDR_W_B-1:0] address2,
    input  logic                chipselect2,
    input  logic                read2,
    input  logic                write2,
    input  logic [RATIO-1:0]    byteenable2,
    input  logic [DATA_W_B-1:0] writedata2,
    output logic                waitrequest2,
    output logic [DATA_W_B-1:0] readdata2,
    output logic                readdatavalid2,
    output logic [15:0]         collision_cnt
);

    localparam int unsigned LOG2R  = $clog2(RATIO);
    localparam int unsigned LANE_W = (LOG2R == 0) ? 1 : LOG2R;

    logic [DATA_W_B-1:0] r_mem [DEPTH_B];

    logic                w_en;
    logic                w_wr_a, w_rd_a, w_wr_b, w_rd_b;
    logic [ADDR_W_B-1:0] w_word_a;
    logic [LANE_W-1:0]   w_lane_a;
    logic [RATIO-1:0]    w_mask_a, w_mask_b;
    logic                w_same_word, w_coll;
    logic [DATA_W_B-1:0] w_fwd_a, w_fwd_b;
    logic [DATA_W_A-1:0] w_rdata_a;

    logic                r_v1_a, r_v2_a, r_v1_b, r_v2_b;
    logic [DATA_W_A-1:0] r_d1_a, r_d2_a;
    logic [DATA_W_B-1:0] r_d1_b, r_d2_b;
    logic [15:0]         r_coll_cnt;

    // Shared stall: both ports freeze together
    assign w_en         = clken & ~reset_req;
    assign waitrequest  = ~w_en;
    assign waitrequest2 = ~w_en;

    // Accepted commands; read together with write is treated as a write
    assign w_wr_a = w_en & chipselect  & write;
    assign w_rd_a = w_en & chipselect  & read  & ~write;
    assign w_wr_b = w_en & chipselect2 & write2;
    assign w_rd_b = w_en & chipselect2 & read2 & ~write2;

    // Port A lane address -> word + little-endian lane
    assign w_word_a = ADDR_W_B'(address >> LOG2R);
    assign w_lane_a = (LOG2R == 0) ? '0 : LANE_W'(address);

    assign w_same_word = (w_word_a == address2);
    assign w_coll      = w_wr_a & w_wr_b & w_same_word & byteenable2[w_lane_a];

    // Per-lane write masks for both ports
    always_comb begin
        w_mask_a = '0;
        if (w_wr_a) w_mask_a[w_lane_a] = 1'b1;
        w_mask_b = w_wr_b ? byteenable2 : '0;
    end

    // Read paths see the other port's same-cycle write (new-data semantics)
    always_comb begin
        w_fwd_a = r_mem[w_word_a];
        if (w_wr_b && w_same_word) begin
            for (int k = 0; k < int'(RATIO); k++) begin
                if (byteenable2[k]) w_fwd_a[k*DATA_W_A +: DATA_W_A] = writedata2[k*DATA_W_A +: DATA_W_A];
            end
        end
        w_fwd_b = r_mem[address2];
        if (w_wr_a && w_same_word) w_fwd_b[w_lane_a*DATA_W_A +: DATA_W_A] = writedata;
    end

    assign w_rdata_a = w_fwd_a[w_lane_a*DATA_W_A +: DATA_W_A];

    // RAM array; port B is applied last so it owns a colliding lane
    always_ff @(posedge clk) begin
        for (int k = 0; k < int'(RATIO); k++) begin
            if (w_mask_a[k]) r_mem[w_word_a][k*DATA_W_A +: DATA_W_A] <= writedata;
            if (w_mask_b[k]) r_mem[address2][k*DATA_W_A +: DATA_W_A] <= writedata2[k*DATA_W_A +: DATA_W_A];
        end
    end

    // Read pipelines and collision counter; frozen while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1_a     <= 1'b0;
            r_v2_a     <= 1'b0;
            r_d1_a     <= '0;
            r_d2_a     <= '0;
            r_v1_b     <= 1'b0;
            r_v2_b     <= 1'b0;
            r_d1_b     <= '0;
            r_d2_b     <= '0;
            r_coll_cnt <= '0;
        end else if (w_en) begin
            r_v1_a <= w_rd_a;
            r_v2_a <= r_v1_a;
            r_v1_b <= w_rd_b;
            r_v2_b <= r_v1_b;
            if (w_rd_a) r_d1_a <= w_rdata_a;
            if (r_v1_a) r_d2_a <= r_d1_a;
            if (w_rd_b) r_d1_b <= w_fwd_b;
            if (r_v1_b) r_d2_b <= r_d1_b;
            if (w_coll && (r_coll_cnt != 16'hFFFF)) r_coll_cnt <= r_coll_cnt + 16'd1;
        end
    end

    assign readdata       = OUTREG ? r_d2_a : r_d1_a;
    assign readdatavalid  = OUTREG ? r_v2_a : r_v1_a;
    assign readdata2      = OUTREG ? r_d2_b : r_d1_b;
    assign readdatavalid2 = OUTREG ? r_v2_b : r_v1_b;
    assign collision_cnt  = r_coll_cnt;

endmodule

// File: tb/tb_qtest_dpram_avmm.sv
// Bench for qtest_dpram_avmm (RATIO=8, 8-bit lanes, OUTREG=1).
// The model tracks memory contents, pending reads (with their due times counted in
// enabled cycles), and the collision count. A compare process checks the DUT outputs
// against this model on every cycle. Directed sequences use literal expectations to pin
// the model.
module tb_qtest_dpram_avmm;

    localparam bit          OUTREG  = 1'b1;
    localparam int unsigned LAT     = OUTREG ? 2 : 1;
    localparam int unsigned DEPTH_B = 16384;

    logic        clk = 1'b0, reset = 1'b1, clken = 1'b1, reset_req = 1'b0;
    logic [16:0] address = '0;
    logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
    logic [7:0]  writedata = '0;
    logic        waitrequest, readdatavalid;
    logic [7:0]  readdata;
    logic [13:0] address2 = '0;
    logic        chipselect2 = 1'b0, read2 = 1'b0, write2 = 1'b0;
    logic [7:0]  byteenable2 = '0;
    logic [63:0] writedata2 = '0;
    logic        waitrequest2, readdatavalid2;
    logic [63:0] readdata2;
    logic [15:0] collision_cnt;

    int n_vec = 0;
    int n_err = 0;

    qtest_dpram_avmm #(.DATA_W_A(8), .RATIO(8), .DEPTH_B(DEPTH_B), .ADDR_W_B(14), .OUTREG(OUTREG)) dut (
        .clk(clk), .reset(reset), .clken(clken), .reset_req(reset_req),
        .address(address), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata),
        .readdatavalid(readdatavalid),
        .address2(address2), .chipselect2(chipselect2), .read2(read2), .write2(write2),
        .byteenable2(byteenable2), .writedata2(writedata2), .waitrequest2(waitrequest2),
        .readdata2(readdata2), .readdatavalid2(readdatavalid2), .collision_cnt(collision_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed { int unsigned due; logic [63:0] d; } rd_t;
    logic [63:0] m_mem [DEPTH_B];
    rd_t         qa[$], qb[$];
    int unsigned en_n = 0;
    logic        m_va = 0, m_vb = 0, m_edge_en = 0;
    logic [7:0]  m_da = 0;
    logic [63:0] m_db = 0;
    logic [15:0] m_cnt = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            qa.delete(); qb.delete();
            m_va = 0; m_vb = 0; m_da = 0; m_db = 0; m_cnt = 0; m_edge_en = 0;
        end else begin
            m_edge_en = clken && !reset_req;
            if (m_edge_en) begin
                int unsigned wa_word, lane;
                logic wa, ra, wb, rb;
                en_n++;
                wa_word = int'(address) / 8;
                lane    = int'(address) % 8;
                wa = chipselect && write;
                ra = chipselect && read && !write;
                wb = chipselect2 && write2;
                rb = chipselect2 && read2 && !write2;
                if (wa && wb && wa_word == int'(address2) && byteenable2[lane] && m_cnt != 16'hFFFF)
                    m_cnt = m_cnt + 16'd1;
                if (wa) m_mem[wa_word][lane*8 +: 8] = writedata;
                for (int k = 0; k < 8; k++)
                    if (wb && byteenable2[k]) m_mem[address2][k*8 +: 8] = writedata2[k*8 +: 8];
                // Reads see the memory after this cycle's writes
                if (ra) qa.push_back('{due: en_n + LAT - 1, d: {56'd0, m_mem[wa_word][lane*8 +: 8]}});
                if (rb) qb.push_back('{due: en_n + LAT - 1, d: m_mem[address2]});
                m_va = 0;
                if (qa.size() > 0 && qa[0].due == en_n) begin
                    m_va = 1; m_da = qa[0].d[7:0]; void'(qa.pop_front());
                end
                m_vb = 0;
                if (qb.size() > 0 && qb[0].due == en_n) begin
                    m_vb = 1; m_db = qb[0].d; void'(qb.pop_front());
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0]  got_a[$];
    logic [63:0] got_b[$];

    always @(posedge clk) begin
        #1;
        chk("waitrequest", {63'd0, waitrequest}, {63'd0, !clken || reset_req});
        chk("waitrequest2", {63'd0, waitrequest2}, {63'd0, !clken || reset_req});
        chk("readdatavalid", {63'd0, readdatavalid}, {63'd0, m_va});
        chk("readdatavalid2", {63'd0, readdatavalid2}, {63'd0, m_vb});
        if (m_va) chk("readdata", {56'd0, readdata}, {56'd0, m_da});
        if (m_vb) chk("readdata2", readdata2, m_db);
        chk("collision_cnt", {48'd0, collision_cnt}, {48'd0, m_cnt});
        if (readdatavalid && m_edge_en) got_a.push_back(readdata);
        if (readdatavalid2 && m_edge_en) got_b.push_back(readdata2);
    end

    // ---------------- directed stimulus ----------------
    task automatic idle();
        chipselect = 0; read = 0; write = 0;
        chipselect2 = 0; read2 = 0; write2 = 0; byteenable2 = '0;
    endtask

    task automatic b_wr(input int unsigned w, input logic [7:0] be, input logic [63:0] d);
        chipselect2 = 1; write2 = 1; address2 = 14'(w); byteenable2 = be; writedata2 = d;
        @(negedge clk); idle();
    endtask

    task automatic b_rd(input int unsigned w);
        chipselect2 = 1; read2 = 1; address2 = 14'(w);
        @(negedge clk); idle();
    endtask

    task automatic drain();
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic exp_b(input string nm, input int idx, input logic [63:0] e);
        if (idx < got_b.size()) chk(nm, got_b[idx], e);
        else chk({nm, "_missing"}, 64'd0, e | 64'd1);
    endtask

    task automatic exp_a(input string nm, input int idx, input logic [7:0] e);
        if (idx < got_a.size()) chk(nm, {56'd0, got_a[idx]}, {56'd0, e});
        else chk({nm, "_missing"}, 64'd0, 64'd1);
    endtask

    initial begin
        int nb, na;
        repeat (3) @(negedge clk);
        reset = 0;
        @(negedge clk);
        chk("rst_readdata2", readdata2, 64'd0);
        chk("rst_valid2", {63'd0, readdatavalid2}, 64'd0);
        chk("rst_cnt", {48'd0, collision_cnt}, 64'd0);

        // 1: reset during an in-flight B read
        b_wr(3, 8'hFF, 64'hDEADBEEF_CAFEF00D);
        nb = got_b.size();
        chipselect2 = 1; read2 = 1; address2 = 14'd3;
        @(negedge clk); idle();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
        drain();
        chk("t1_no_pulse", 64'(got_b.size()), 64'(nb));
        chk("t1_readdata2_zero", readdata2, 64'd0);
        b_rd(3); drain();
        exp_b("t1_ram_kept", nb, 64'hDEADBEEF_CAFEF00D);

        // 2: width mapping, back-to-back A reads
        b_wr(5, 8'hFF, 64'h0807060504030201);
        na = got_a.size();
        for (int i = 40; i < 48; i++) begin
            chipselect = 1; read = 1; address = 17'(i);
            @(negedge clk);
        end
        idle(); drain();
        for (int i = 0; i < 8; i++) exp_a($sformatf("t2_lane%0d", i), na + i, 8'(i + 1));

        // 3: byte enables
        nb = got_b.size();
        b_wr(5, 8'h0F, 64'hFFFF_FFFF_FFFF_FFFF);
        b_rd(5); drain();
        exp_b("t3_be", nb, 64'h08070605_FFFFFFFF);

        // 4: same-lane collision, then adjacent-lane write to the same word
        chipselect = 1; write = 1; address = 17'd41; writedata = 8'hAA;
        b_wr(5, 8'h02, 64'h0000_0000_0000_5500);
        b_rd(5); drain();
        exp_b("t4_b_wins", nb + 1, 64'h08070605_FFFF55FF);
        chk("t4_cnt1", {48'd0, collision_cnt}, 64'd1);
        chipselect = 1; write = 1; address = 17'd41; writedata = 8'hAA;
        b_wr(5, 8'h01, 64'h0000_0000_0000_5500);
        b_rd(5); drain();
        exp_b("t4_both_commit", nb + 2, 64'h08070605_FFFFAA00);
        chk("t4_cnt_stays", {48'd0, collision_cnt}, 64'd1);

        // 5: mixed-port forwarding in both directions
        na = got_a.size();
        chipselect = 1; read = 1; address = 17'd42;
        b_wr(5, 8'h04, 64'h0000_0000_0077_0000);
        drain();
        exp_a("t5_fwd_a", na, 8'h77);
        chipselect = 1; write = 1; address = 17'd43; writedata = 8'h99;
        b_rd(5); drain();
        exp_b("t5_fwd_b", nb + 3, 64'h08070605_9977AA00);

        // 6: burst of 8 B reads with clken and reset_req stalls in the middle
        for (int i = 0; i < 8; i++) b_wr(100 + i, 8'hFF, {8{8'(i + 16)}});
        nb = got_b.size();
        for (int i = 0; i < 8; i++) begin
            chipselect2 = 1; read2 = 1; address2 = 14'(100 + i);
            if (i == 3) begin
                clken = 0;
                #1 chk("t6_wait2_hi", {63'd0, waitrequest2}, 64'd1);
                repeat (3) @(negedge clk);
                clken = 1;
            end
            if (i == 6) begin
                reset_req = 1;
                @(negedge clk);
                reset_req = 0;
            end
            @(negedge clk);
        end
        idle(); drain();
        chk("t6_count", 64'(got_b.size() - nb), 64'd8);
        for (int i = 0; i < 8; i++) exp_b($sformatf("t6_rd%0d", i), nb + i, {8{8'(i + 16)}});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
